// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and nibble decode for all display tops.
// Segment order {a,b,c,d,e,f,g} MSB..LSB, active-low (0 = lit).
// Pure constants and a function; no timing or flow control involved.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// Purpose: one hex digit, nibble -> active-low segments, with forced blank.
// Latency: combinational. Backpressure: none.
// Ports: nibble (4-bit value), blank (1 = all segments off), seg (7-bit {a..g}).
module hex_seg_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : hex_to_seg(nibble);

endmodule

// File: rtl/param_updown_counter_hex.sv
// Purpose: modulo-N up/down counter with sync clear/load, registered wrap pulse, hex display.
// Latency: count/tc update 1 clk after controls sampled; hex is combinational from count.
// Backpressure: none; priority sclr > load > enable > hold.
// Ports: clk, aclr (async, active-low), sclr, load, load_value[WIDTH], enable, up,
//        count[WIDTH] (registered), tc (registered wrap pulse), hex[7*NDIGITS] (active-low).
module param_updown_counter_hex #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULUS  = 256,
  parameter bit              BLANK_LZ = 1'b0,
  localparam int unsigned    NDIGITS  = (WIDTH + 3) / 4
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 sclr,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_value,
  input  logic                 enable,
  input  logic                 up,
  output logic [WIDTH-1:0]     count,
  output logic                 tc,
  output logic [7*NDIGITS-1:0] hex
);

  // MODULUS may be 2**32 when WIDTH=32, so the terminal value is derived in 64 bits.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  logic load_over;
  assign load_over = (64'(load_value) >= MODULUS);

  // Wrap is detected by comparing before stepping, so count never leaves 0..MODULUS-1.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (sclr) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (load) begin
      count <= load_over ? MAX_VAL : load_value;
      tc    <= 1'b0;
    end else if (enable) begin
      if (up) begin
        if (count == MAX_VAL) begin
          count <= '0;
          tc    <= 1'b1;
        end else begin
          count <= count + WIDTH'(1);
          tc    <= 1'b0;
        end
      end else begin
        if (count == '0) begin
          count <= MAX_VAL;
          tc    <= 1'b1;
        end else begin
          count <= count - WIDTH'(1);
          tc    <= 1'b0;
        end
      end
    end else begin
      tc <= 1'b0;
    end
  end

  // Zero-extend to a whole number of nibbles so the top digit decodes cleanly.
  logic [4*NDIGITS-1:0] padded;
  assign padded = (4 * NDIGITS)'(count);

  for (genvar d = 0; d < NDIGITS; d++) begin : g_digit
    logic upper_nz;
    logic blank;
    // A digit is a leading zero when it and every digit above it are zero.
    assign upper_nz = |padded[4*NDIGITS-1:4*d];
    assign blank    = BLANK_LZ && (d > 0) && !upper_nz;

    hex_seg_decoder u_dec (
      .nibble (padded[4*d +: 4]),
      .blank  (blank),
      .seg    (hex[7*d +: 7])
    );
  end

endmodule

// File: tb/tb_param_updown_counter_hex.sv
module tb_param_updown_counter_hex;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b1100000;
  localparam logic [6:0] SF = 7'b0111000;
  localparam logic [6:0] SX = 7'b1111111;

  int total = 0;
  int bad   = 0;

  logic clk  = 1'b0;
  logic aclr = 1'b1;

  // Instance A: WIDTH=8, MODULUS=256
  logic        a_sclr = 0, a_load = 0, a_en = 0, a_up = 1;
  logic [7:0]  a_lv = '0;
  logic [7:0]  a_count;
  logic        a_tc;
  logic [13:0] a_hex;

  // Instance B: WIDTH=8, MODULUS=60
  logic        b_sclr = 0, b_load = 0, b_en = 0, b_up = 1;
  logic [7:0]  b_lv = '0;
  logic [7:0]  b_count;
  logic        b_tc;
  logic [13:0] b_hex;

  // Instance C: WIDTH=12, MODULUS=4096, leading-zero blanking
  logic        c_sclr = 0, c_load = 0, c_en = 0, c_up = 1;
  logic [11:0] c_lv = '0;
  logic [11:0] c_count;
  logic        c_tc;
  logic [20:0] c_hex;

  param_updown_counter_hex #(.WIDTH(8), .MODULUS(256), .BLANK_LZ(1'b0)) u_a (
    .clk(clk), .aclr(aclr), .sclr(a_sclr), .load(a_load), .load_value(a_lv),
    .enable(a_en), .up(a_up), .count(a_count), .tc(a_tc), .hex(a_hex));

  param_updown_counter_hex #(.WIDTH(8), .MODULUS(60), .BLANK_LZ(1'b0)) u_b (
    .clk(clk), .aclr(aclr), .sclr(b_sclr), .load(b_load), .load_value(b_lv),
    .enable(b_en), .up(b_up), .count(b_count), .tc(b_tc), .hex(b_hex));

  param_updown_counter_hex #(.WIDTH(12), .MODULUS(4096), .BLANK_LZ(1'b1)) u_c (
    .clk(clk), .aclr(aclr), .sclr(c_sclr), .load(c_load), .load_value(c_lv),
    .enable(c_en), .up(c_up), .count(c_count), .tc(c_tc), .hex(c_hex));

  always #5 clk = ~clk;

  // Inputs change and outputs are observed 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 aclr = 1'b0;
    #1;
    total++;
    if (a_count !== 8'h00 || a_tc !== 1'b0 || a_hex !== {S0, S0}) begin
      bad++;
      $display("FAIL reset_a: count=%h tc=%b hex=%b want 00/0/%b", a_count, a_tc, a_hex, {S0, S0});
    end
    total++;
    if (b_count !== 8'h00 || b_tc !== 1'b0) begin
      bad++;
      $display("FAIL reset_b: count=%h tc=%b want 00/0", b_count, b_tc);
    end
    total++;
    if (c_count !== 12'h000 || c_hex !== {SX, SX, S0}) begin
      bad++;
      $display("FAIL reset_c: count=%h hex=%b want 000/%b", c_count, c_hex, {SX, SX, S0});
    end
    aclr = 1'b1;
  endtask

  task automatic test_async_clear();
    a_load = 1; a_lv = 8'h5A;
    step();
    a_load = 0;
    total++;
    if (a_count !== 8'h5A) begin
      bad++;
      $display("FAIL preload_5a: count=%h want 5a", a_count);
    end
    #2 aclr = 1'b0;
    #1;
    total++;
    if (a_count !== 8'h00 || a_tc !== 1'b0 || a_hex !== {S0, S0}) begin
      bad++;
      $display("FAIL aclr_midcount: count=%h tc=%b hex=%b want 00/0/%b", a_count, a_tc, a_hex, {S0, S0});
    end
    aclr = 1'b1;
  endtask

  task automatic test_wrap_up();
    step();
    a_load = 1; a_lv = 8'hFE;
    step();
    a_load = 0; a_en = 1; a_up = 1;
    step();
    total++;
    if (a_count !== 8'hFF || a_tc !== 1'b0 || a_hex !== {SF, SF}) begin
      bad++;
      $display("FAIL up_ff: count=%h tc=%b hex=%b want ff/0/%b", a_count, a_tc, a_hex, {SF, SF});
    end
    step();
    total++;
    if (a_count !== 8'h00 || a_tc !== 1'b1 || a_hex !== {S0, S0}) begin
      bad++;
      $display("FAIL up_wrap: count=%h tc=%b hex=%b want 00/1/%b", a_count, a_tc, a_hex, {S0, S0});
    end
    a_en = 0;
    step();
    total++;
    if (a_count !== 8'h00 || a_tc !== 1'b0) begin
      bad++;
      $display("FAIL tc_one_cycle: count=%h tc=%b want 00/0", a_count, a_tc);
    end
  endtask

  task automatic test_wrap_down_mod60();
    b_sclr = 1;
    step();
    b_sclr = 0; b_en = 1; b_up = 0;
    step();
    total++;
    if (b_count !== 8'd59 || b_tc !== 1'b1 || b_hex !== {S3, SB}) begin
      bad++;
      $display("FAIL down_wrap60: count=%0d tc=%b hex=%b want 59/1/%b", b_count, b_tc, b_hex, {S3, SB});
    end
    step();
    total++;
    if (b_count !== 8'd58 || b_tc !== 1'b0) begin
      bad++;
      $display("FAIL down_58: count=%0d tc=%b want 58/0", b_count, b_tc);
    end
    b_en = 0;
  endtask

  task automatic test_load_priority();
    b_load = 1; b_lv = 8'd200;
    step();
    total++;
    if (b_count !== 8'd59 || b_tc !== 1'b0) begin
      bad++;
      $display("FAIL load_clamp200: count=%0d tc=%b want 59/0", b_count, b_tc);
    end
    b_lv = 8'd60;
    step();
    total++;
    if (b_count !== 8'd59) begin
      bad++;
      $display("FAIL load_clamp60: count=%0d want 59", b_count);
    end
    b_lv = 8'd12;
    step();
    total++;
    if (b_count !== 8'd12) begin
      bad++;
      $display("FAIL load_12: count=%0d want 12", b_count);
    end
    b_sclr = 1; b_load = 1; b_en = 1; b_lv = 8'd33;
    step();
    b_sclr = 0; b_load = 0; b_en = 0;
    total++;
    if (b_count !== 8'd0 || b_tc !== 1'b0) begin
      bad++;
      $display("FAIL sclr_wins: count=%0d tc=%b want 0/0", b_count, b_tc);
    end
  endtask

  task automatic test_hold_and_load_enable();
    a_load = 1; a_lv = 8'h33;
    step();
    a_load = 0; a_en = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (a_count !== 8'h33 || a_tc !== 1'b0) begin
        bad++;
        $display("FAIL hold_%0d: count=%h tc=%b want 33/0", i, a_count, a_tc);
      end
    end
    a_load = 1; a_en = 1; a_up = 1; a_lv = 8'd7;
    step();
    a_load = 0;
    total++;
    if (a_count !== 8'd7) begin
      bad++;
      $display("FAIL load_beats_enable: count=%0d want 7", a_count);
    end
    step();
    total++;
    if (a_count !== 8'd8) begin
      bad++;
      $display("FAIL up_after_load: count=%0d want 8", a_count);
    end
    a_up = 0;
    step();
    total++;
    if (a_count !== 8'd7) begin
      bad++;
      $display("FAIL dir_change: count=%0d want 7", a_count);
    end
    a_en = 0;
  endtask

  task automatic test_back_to_back();
    b_load = 1; b_lv = 8'd59;
    step();
    b_load = 0; b_en = 1; b_up = 1;
    step();
    total++;
    if (b_count !== 8'd0 || b_tc !== 1'b1) begin
      bad++;
      $display("FAIL b2b_up: count=%0d tc=%b want 0/1", b_count, b_tc);
    end
    b_up = 0;
    step();
    total++;
    if (b_count !== 8'd59 || b_tc !== 1'b1) begin
      bad++;
      $display("FAIL b2b_down: count=%0d tc=%b want 59/1", b_count, b_tc);
    end
    b_en = 0;
    step();
    total++;
    if (b_count !== 8'd59 || b_tc !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: count=%0d tc=%b want 59/0", b_count, b_tc);
    end
  endtask

  task automatic test_blank_lz();
    c_load = 1; c_lv = 12'h00A;
    step();
    total++;
    if (c_count !== 12'h00A || c_hex !== {SX, SX, SA}) begin
      bad++;
      $display("FAIL blank_00a: count=%h hex=%b want 00a/%b", c_count, c_hex, {SX, SX, SA});
    end
    c_lv = 12'h10A;
    step();
    total++;
    if (c_hex !== {S1, S0, SA}) begin
      bad++;
      $display("FAIL noblank_10a: hex=%b want %b", c_hex, {S1, S0, SA});
    end
    c_lv = 12'h000;
    step();
    c_load = 0;
    total++;
    if (c_hex !== {SX, SX, S0}) begin
      bad++;
      $display("FAIL blank_000: hex=%b want %b", c_hex, {SX, SX, S0});
    end
  endtask

  initial begin
    test_reset();
    test_async_clear();
    test_wrap_up();
    test_wrap_down_mod60();
    test_load_priority();
    test_hold_and_load_enable();
    test_back_to_back();
    test_blank_lz();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
